// File: rtl/pixel_readout_pkg.sv
// Shared types for the pixel readout stage: FSM state encoding, tagged
// sample layout and default sample width.
package pixel_readout_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ROW0,
    ROW1
  } state_t;

  // Layout of one FIFO word; the top packs {row, col, data} in this order.
  typedef struct packed {
    logic                      row;
    logic                      col;
    logic [DEFAULT_DATA_W-1:0] data;
  } sample_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with registered storage; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module pixel_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_readout.sv
// Captures one ADC sample per conversion strobe, tags it with row/column and
// buffers it for a valid/ready consumer. Macro PIXEL_READOUT_DARK_SUB_EN
// enables saturating dark-level subtraction.
module pixel_readout
  import pixel_readout_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int DARK_OFFSET = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              NRE_1,
  input  logic              NRE_2,
  input  logic              ADC,
  input  logic [DATA_W-1:0] Adc_data,
  output logic [DATA_W-1:0] Pixel_data,
  output logic              Pixel_row,
  output logic              Pixel_col,
  output logic              Pixel_valid,
  input  logic              Pixel_ready,
  output logic              Frame_done,
  output logic              Overflow,
  output logic              Seq_error
);

`ifdef PIXEL_READOUT_DARK_SUB_EN
  localparam bit DARK_EN = 1'b1;
`else
  localparam bit DARK_EN = 1'b0;
`endif

  state_t            state;
  state_t            state_next;
  logic              adc_q;
  logic              strobe;
  logic              sel_row0;
  logic              sel_row1;
  logic              sel_none;
  logic              sel_both;
  logic [1:0]        col;
  logic              cur_row;
  logic              tag_ok;
  logic              seq_bad;
  logic              pop_fire;
  logic              drop;
  logic              accepted;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] dark_level;
  logic [DATA_W-1:0] sample;
  logic [DATA_W+1:0] head;

  assign strobe   = ADC & ~adc_q;
  assign sel_row0 = ~NRE_1 &  NRE_2;
  assign sel_row1 =  NRE_1 & ~NRE_2;
  assign sel_none =  NRE_1 &  NRE_2;
  assign sel_both = ~NRE_1 & ~NRE_2;
  assign cur_row  = (state == ROW1);

  assign tag_ok   = strobe & (state != IDLE) & ~sel_both & (col != 2'd2);
  assign seq_bad  = strobe & ((state == IDLE) | sel_both | (col == 2'd2));
  assign pop_fire = Pixel_valid & Pixel_ready;
  assign drop     = tag_ok & full & ~pop_fire;
  assign accepted = tag_ok & ~drop;

  assign dark_level = DATA_W'(DARK_OFFSET);
  assign sample = DARK_EN ? ((Adc_data > dark_level) ? Adc_data - dark_level : '0)
                          : Adc_data;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (sel_row0)      state_next = ROW0;
        else if (sel_row1) state_next = ROW1;
      end
      ROW0: begin
        if (sel_row1)      state_next = ROW1;
        else if (sel_none) state_next = IDLE;
      end
      ROW1: begin
        if (sel_row0)      state_next = ROW0;
        else if (sel_none) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Column advances on every well-tagged strobe, even one lost to overflow.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      adc_q      <= 1'b0;
      col        <= '0;
      Frame_done <= 1'b0;
      Overflow   <= 1'b0;
      Seq_error  <= 1'b0;
    end else begin
      state      <= state_next;
      adc_q      <= ADC;
      if (state_next != state) col <= '0;
      else if (tag_ok)         col <= col + 2'd1;
      Frame_done <= accepted & cur_row & (col == 2'd1);
      Overflow   <= Overflow | drop;
      Seq_error  <= Seq_error | seq_bad;
    end
  end

  pixel_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .reset (Reset),
    .push  (tag_ok),
    .pop   (Pixel_ready),
    .wdata ({cur_row, col[0], sample}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign Pixel_valid = ~empty;
  assign {Pixel_row, Pixel_col, Pixel_data} = head;

endmodule

// File: tb/tb_pixel_readout.sv
// Self-checking bench for pixel_readout: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_pixel_readout;

  localparam int DEPTH = 4;
  localparam logic [7:0] DARK = 8'h20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       nre1 = 1'b1;
  logic       nre2 = 1'b1;
  logic       adc = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] adc_data = 8'h00;
  logic [7:0] pix_data;
  logic       pix_row;
  logic       pix_col;
  logic       pix_valid;
  logic       frame_done;
  logic       overflow;
  logic       seq_error;

  int checks = 0;
  int failures = 0;

  // Reference model state: active row (-1 none), next column, stored samples.
  logic [9:0] m_q[$];
  int m_row = -1;
  int m_col = 0;
  bit m_ovf = 0;
  bit m_seq = 0;
  bit m_fd = 0;
  bit m_prev = 0;

  pixel_readout #(
    .DATA_W      (8),
    .FIFO_DEPTH  (DEPTH),
    .DARK_OFFSET (32'h20)
  ) dut (
    .Clk         (clk),
    .Reset       (rst),
    .NRE_1       (nre1),
    .NRE_2       (nre2),
    .ADC         (adc),
    .Adc_data    (adc_data),
    .Pixel_data  (pix_data),
    .Pixel_row   (pix_row),
    .Pixel_col   (pix_col),
    .Pixel_valid (pix_valid),
    .Pixel_ready (ready),
    .Frame_done  (frame_done),
    .Overflow    (overflow),
    .Seq_error   (seq_error)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] dk(logic [7:0] x);
`ifdef PIXEL_READOUT_DARK_SUB_EN
    return (x > DARK) ? x - DARK : 8'h00;
`else
    return x;
`endif
  endfunction

  function automatic logic [12:0] w(int rn, int n1, int n2, int a, int r, int d);
    return {rn[0], n1[0], n2[0], a[0], r[0], d[7:0]};
  endfunction

  task automatic drive(logic [12:0] v);
    {rst, nre1, nre2, adc, ready, adc_data} = v;
  endtask

  function automatic logic [13:0] model_vec();
    return {m_q.size() != 0, (m_q.size() != 0) ? m_q[0] : 10'h0, m_fd, m_ovf, m_seq};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {pix_valid, (m_q.size() != 0) ? {pix_row, pix_col, pix_data} : 10'h0,
            frame_done, overflow, seq_error};
  endfunction

  // Advance model with the inputs present before the edge, then clock the DUT.
  task automatic tick();
    bit strobe;
    int nxt;
    if (!rst) begin
      m_q.delete();
      m_row = -1; m_col = 0; m_ovf = 0; m_seq = 0; m_fd = 0; m_prev = 0;
    end else begin
      strobe = adc && !m_prev;
      if (ready && m_q.size() > 0) void'(m_q.pop_front());
      m_fd = 0;
      if (strobe) begin
        if (m_row < 0 || (!nre1 && !nre2) || m_col >= 2) m_seq = 1;
        else begin
          if (m_q.size() >= DEPTH) m_ovf = 1;
          else begin
            m_q.push_back({m_row[0], m_col[0], dk(adc_data)});
            m_fd = (m_row == 1 && m_col == 1);
          end
          m_col++;
        end
      end
      if (nre1 && !nre2)      nxt = 1;
      else if (!nre1 && nre2) nxt = 0;
      else if (nre1 && nre2)  nxt = -1;
      else                    nxt = m_row;
      if (nxt != m_row) begin
        m_row = nxt;
        m_col = 0;
      end
      m_prev = adc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(w(0, 1, 1, 0, 0, 0));
    tick();
    checks++;
    if ({pix_valid, pix_row, pix_col, pix_data} !== 11'h0) begin
      failures++;
      $display("FAIL reset_head got=%b/%b/%b/%h want=0/0/0/00", pix_valid, pix_row, pix_col, pix_data);
    end
    checks++;
    if ({frame_done, overflow, seq_error} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000", {frame_done, overflow, seq_error});
    end
  endtask

  task automatic test_frame();
    logic [12:0] s[$];
    logic [9:0] got[$];
    logic [9:0] exp_pop[4];
    int fd_cnt = 0;
    int fd_at = -1;
    s = '{w(1,1,1,0,0,0), w(1,0,1,0,0,0), w(1,0,1,1,0,8'h10), w(1,0,1,0,0,0),
          w(1,0,1,1,0,8'h20), w(1,0,1,0,0,0), w(1,1,0,0,0,0), w(1,1,0,1,0,8'h30),
          w(1,1,0,0,0,0), w(1,1,0,1,0,8'h40), w(1,1,0,0,0,0), w(1,1,1,0,1,0),
          w(1,1,1,0,1,0), w(1,1,1,0,1,0), w(1,1,1,0,1,0), w(1,1,1,0,0,0)};
    foreach (s[i]) begin
      drive(s[i]);
      if (pix_valid && ready) got.push_back({pix_row, pix_col, pix_data});
      tick();
      if (frame_done) begin fd_cnt++; fd_at = i; end
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL frame step=%0d dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    exp_pop[0] = {2'b00, dk(8'h10)};
    exp_pop[1] = {2'b01, dk(8'h20)};
    exp_pop[2] = {2'b10, dk(8'h30)};
    exp_pop[3] = {2'b11, dk(8'h40)};
    checks++;
    if (got.size() != 4) begin
      failures++;
      $display("FAIL frame_pop_count got=%0d want=4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== exp_pop[k]) begin
          failures++;
          $display("FAIL frame_pop%0d got=%h want=%h", k, got[k], exp_pop[k]);
        end
      end
    end
    checks++;
    if (fd_cnt != 1 || fd_at != 9) begin
      failures++;
      $display("FAIL frame_done got=%0d pulses at step %0d want=1 at step 9", fd_cnt, fd_at);
    end
  endtask

  task automatic test_overflow_seq();
    logic [12:0] s[$];
    logic [9:0] got[$];
    int vlow = 0;
    bit started = 0;
    s = '{w(0,1,1,0,0,0), w(1,0,1,0,0,0), w(1,0,1,1,0,8'h11), w(1,0,1,0,0,0),
          w(1,0,1,1,0,8'h12), w(1,1,0,0,0,0), w(1,1,0,1,0,8'h13), w(1,1,0,0,0,0),
          w(1,1,0,1,0,8'h14), w(1,1,0,0,0,0), w(1,1,0,1,0,8'h15), w(1,1,0,0,0,0),
          w(1,0,1,0,0,0), w(1,0,1,1,0,8'h16), w(1,0,1,0,0,0), w(1,1,1,0,1,0),
          w(1,1,1,0,1,0), w(1,1,1,0,1,0), w(1,1,1,0,1,0), w(1,1,1,0,1,0)};
    foreach (s[i]) begin
      drive(s[i]);
      if (pix_valid && ready) got.push_back({pix_row, pix_col, pix_data});
      if (!ready && started && !pix_valid) vlow++;
      tick();
      if (pix_valid) started = 1;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL ovf_seq step=%0d dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if ({overflow, seq_error} !== 2'b11 || vlow != 0) begin
      failures++;
      $display("FAIL ovf_seq_flags got ovf=%b seq=%b vlow=%0d want 1 1 0", overflow, seq_error, vlow);
    end
    checks++;
    if (got.size() != 4 || got[0] !== {2'b00, dk(8'h11)} || got[3] !== {2'b11, dk(8'h14)}) begin
      failures++;
      $display("FAIL ovf_seq_stored got n=%0d want 4 samples 11..14", got.size());
    end
  endtask

  task automatic test_full_pop();
    logic [12:0] s[$];
    logic [9:0] got[$];
    logic [9:0] exp_pop[5];
    s = '{w(0,1,1,0,0,0), w(1,0,1,0,0,0), w(1,0,1,1,0,8'h21), w(1,0,1,0,0,0),
          w(1,0,1,1,0,8'h22), w(1,1,0,0,0,0), w(1,1,0,1,0,8'h23), w(1,1,0,0,0,0),
          w(1,1,0,1,0,8'h24), w(1,1,0,0,0,0), w(1,0,1,0,0,0), w(1,0,1,1,1,8'h25),
          w(1,0,1,0,0,0), w(1,1,1,0,1,0), w(1,1,1,0,1,0), w(1,1,1,0,1,0),
          w(1,1,1,0,1,0), w(1,1,1,0,1,0)};
    foreach (s[i]) begin
      drive(s[i]);
      if (pix_valid && ready) got.push_back({pix_row, pix_col, pix_data});
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL full_pop step=%0d dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    exp_pop = '{{2'b00, dk(8'h21)}, {2'b01, dk(8'h22)}, {2'b10, dk(8'h23)},
                {2'b11, dk(8'h24)}, {2'b00, dk(8'h25)}};
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_ovf got=%b want=0", overflow);
    end
    checks++;
    if (got.size() != 5) begin
      failures++;
      $display("FAIL full_pop_count got=%0d want=5", got.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (got[k] !== exp_pop[k]) begin
          failures++;
          $display("FAIL full_pop%0d got=%h want=%h", k, got[k], exp_pop[k]);
        end
      end
    end
  endtask

  task automatic test_adc_hold();
    logic [12:0] s[$];
    logic [9:0] got[$];
    s = '{w(0,1,1,0,0,0), w(1,0,1,0,0,0), w(1,0,1,1,0,8'h5A)};
    for (int k = 0; k < 9; k++) s.push_back(w(1, 0, 1, 1, 0, int'($urandom_range(255))));
    s.push_back(w(1,0,1,0,0,0));
    s.push_back(w(1,1,1,0,0,0));
    s.push_back(w(1,1,1,1,0,8'h77));
    s.push_back(w(1,1,1,0,0,0));
    for (int k = 0; k < 3; k++) s.push_back(w(1,1,1,0,1,0));
    foreach (s[i]) begin
      drive(s[i]);
      if (pix_valid && ready) got.push_back({pix_row, pix_col, pix_data});
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL adc_hold step=%0d dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (got.size() != 1 || got[0] !== {2'b00, dk(8'h5A)} || seq_error !== 1'b1) begin
      failures++;
      $display("FAIL adc_hold_result got n=%0d seq=%b want n=1 sample 5A seq=1", got.size(), seq_error);
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] s[$];
    logic [12:0] s2[$];
    s = '{w(0,1,1,0,0,0), w(1,0,1,0,0,0), w(1,0,1,1,0,8'h61), w(1,0,1,0,0,0),
          w(1,0,1,1,0,8'h62), w(1,1,0,0,0,0), w(1,1,0,1,0,8'h63), w(1,1,0,0,0,0),
          w(1,0,0,1,0,8'h99), w(1,0,0,0,0,0), w(0,0,1,0,0,0)};
    s2 = '{w(1,0,1,0,0,0), w(1,0,1,1,0,8'h66), w(1,0,1,0,0,0)};
    foreach (s[i]) begin
      drive(s[i]);
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL reset_mid step=%0d dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if ({pix_valid, overflow, seq_error, frame_done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_clear got=%b want=0000", {pix_valid, overflow, seq_error, frame_done});
    end
    foreach (s2[i]) begin
      drive(s2[i]);
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL reset_mid2 step=%0d dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if ({pix_valid, pix_row, pix_col, pix_data} !== {3'b100, dk(8'h66)}) begin
      failures++;
      $display("FAIL reset_mid_tag got=%b/%b/%b/%h want=1/0/0/%h",
               pix_valid, pix_row, pix_col, pix_data, dk(8'h66));
    end
  endtask

  task automatic test_dark_sub();
    logic [12:0] s[$];
    logic [9:0] got[$];
    logic [7:0] e0;
    logic [7:0] e1;
`ifdef PIXEL_READOUT_DARK_SUB_EN
    e0 = 8'h30; e1 = 8'h00;
`else
    e0 = 8'h50; e1 = 8'h10;
`endif
    s = '{w(0,1,1,0,0,0), w(1,0,1,0,0,0), w(1,0,1,1,0,8'h50), w(1,0,1,0,0,0),
          w(1,0,1,1,0,8'h10), w(1,1,1,0,1,0), w(1,1,1,0,1,0), w(1,1,1,0,1,0)};
    foreach (s[i]) begin
      drive(s[i]);
      if (pix_valid && ready) got.push_back({pix_row, pix_col, pix_data});
      tick();
    end
    checks++;
    if (got.size() != 2 || got[0][7:0] !== e0 || got[1][7:0] !== e1) begin
      failures++;
      $display("FAIL dark_sub got n=%0d want 2 samples %h %h", got.size(), e0, e1);
    end
  endtask

  task automatic test_random();
    int n1 = 1;
    int n2 = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) begin
        n1 = int'($urandom_range(1));
        n2 = int'($urandom_range(1));
      end
      drive(w(($urandom_range(150) != 0) ? 1 : 0, n1, n2,
              ($urandom_range(2) == 0) ? 1 : 0, ($urandom_range(2) == 0) ? 1 : 0,
              int'($urandom_range(255))));
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL random step=%0d dut=%h model=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_overflow_seq();
    test_full_pop();
    test_adc_hold();
    test_reset_mid();
    test_dark_sub();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_readout.md
# pixel_readout

Downstream stage of the camera controller. Consumes the controller's row-select strobes (NRE_1, NRE_2) and conversion strobe (ADC), and captures one ADC sample per conversion. Each sample is tagged with its row and column in the 2x2 pixel array and held in a small FIFO. Samples are presented to the host or output side over a valid/ready handshake.

## Interface
- DATA_W, 8, ADC sample width in bits
- FIFO_DEPTH, 4, sample buffer depth (power of two, ≥2)
- DARK_OFFSET, 0, dark-level value subtracted when dark subtraction is compiled in

- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  reset: synchronous, active-low; one clock, synchronous reset, active-low
- NRE_1  in  1  row 0 read enable from controller, active-low
- NRE_2  in  1  row 1 read enable from controller, active-low
- ADC  in  1  conversion strobe from controller, active-high level
- Adc_data  in  DATA_W  converter output, valid on the cycle ADC is first seen high
- Pixel_data  out  DATA_W  sample at FIFO head
- Pixel_row  out  1  row tag of head sample
- Pixel_col  out  1  column tag of head sample
- Pixel_valid  out  1  FIFO non-empty
- Pixel_ready  in  1  consumer accepts head when high with Pixel_valid
- Frame_done  out  1  one-cycle pulse when sample {row 1, col 1} is written
- Overflow  out  1  sticky; a sample was dropped because the FIFO was full
- Seq_error  out  1  sticky; strobe arrived with no row, both rows, or column exhausted

## Operation
- ADC edge detect: register ADC as adc_q. A strobe is ADC=1 and adc_q=0.
- Row decode: NRE_1=0 and NRE_2=1 gives row 0. NRE_1=1 and NRE_2=0 gives row 1.
- States: IDLE, ROW0, ROW1.
  - IDLE→ROW0/ROW1 on the matching row decode.
  - ROWn→ROWm (m≠n) on a direct row change.
  - ROWn→IDLE when both NRE are high.
  - Every transition clears the column counter to 0.
- On a strobe in ROWn with col<2: push {row, col, sample} and increment col.
- A strobe with col=2, in IDLE, or with both NRE low: no push, set Seq_error.
- Pop when Pixel_valid and Pixel_ready.
- Push on full: dropped and Overflow set, unless a pop occurs in the same cycle. In that case the push is accepted.
- Push and pop on empty in the same cycle: push lands, pop is ignored because Pixel_valid=0.
- Sample = Adc_data, passed unchanged unless dark subtraction is enabled.
- Reset values: all outputs 0, FIFO empty, state IDLE, col 0, adc_q 0. Reset mid-frame discards buffered samples and clears the sticky flags.

## Timing
- Strobe at cycle t: the sample is written at the end of t. Pixel_valid rises at t+1 if the FIFO was empty.
- Frame_done is high during t+1 only.
- Pop at cycle t: the next head is visible at t+1, or Pixel_valid falls at t+1.
- Overflow and Seq_error assert at t+1 and hold until reset.
- ADC held high for many cycles produces exactly one strobe. ADC must return low for at least one cycle before the next strobe.
- Throughput: one push and one pop per cycle.

## Configuration
- PIXEL_READOUT_DARK_SUB_EN defined: the stored sample is Adc_data − DARK_OFFSET, saturated at 0 (no wrap).
- PIXEL_READOUT_DARK_SUB_EN undefined: the stored sample is raw Adc_data. DARK_OFFSET is ignored.

## Structure
- Shared package holds:
  - the state enum (IDLE, ROW0, ROW1)
  - the tagged sample struct {row, col, data}
  - the default DATA_W
- The FIFO is a natural sub-module: pixel_fifo.
  - Parameterised width and depth.
  - Push/pop/full/empty with simultaneous push/pop on full allowed.
- Edge detection, FSM, tagging and flags stay in pixel_readout.

## Test plan
- Reset low 1 cycle, then NRE_1=0, two ADC pulses with data 0x10 and 0x20; NRE_1=1, NRE_2=0, pulses 0x30 and 0x40; Pixel_ready=1 → four pops in order (0,0,0x10), (0,1,0x20), (1,0,0x30), (1,1,0x40); Frame_done pulses once, after the fourth write.
- Pixel_ready=0, six strobes across rows with FIFO_DEPTH=4 → four stored; the third strobe in a row sets Seq_error, the overflow drop sets Overflow; Pixel_valid=1 throughout.
- FIFO full, a strobe and a pop in the same cycle → new sample accepted, Overflow stays 0, count stays 4.
- ADC held high 10 cycles with NRE_1=0 → exactly one sample; ADC pulse with both NRE high → no push, Seq_error=1.
- Reset asserted mid-frame with 3 samples buffered → next cycle Pixel_valid=0 and flags 0; a following row-0 strobe is tagged col 0.
- With PIXEL_READOUT_DARK_SUB_EN and DARK_OFFSET=0x20: inputs 0x50 and 0x10 → 0x30 and 0x00.
